// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the arbiter and the UART TX module.
// master = arbiter side, slave = producers/UART side.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   Req;
    logic [8*NREQ-1:0] Req_Data;
    logic [NREQ-1:0]   Ack;
    logic              Busy;
    logic              Timeout_Err;
    logic              TX_Done_Sig;
    logic              TX_En_Sig;
    logic [7:0]        TX_Data;

    modport master (
        input  Req,
        input  Req_Data,
        input  TX_Done_Sig,
        output Ack,
        output Busy,
        output Timeout_Err,
        output TX_En_Sig,
        output TX_Data
    );

    modport slave (
        output Req,
        output Req_Data,
        output TX_Done_Sig,
        input  Ack,
        input  Busy,
        input  Timeout_Err,
        input  TX_En_Sig,
        input  TX_Data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// The winner's byte is latched at grant and presented with TX_En_Sig held high
// until TX_Done_Sig; a watchdog aborts a byte whose done never arrives.
// All outputs come straight from flops.
module uart_tx_arbiter #(
    parameter int          NREQ    = 4,
    parameter logic [31:0] TIMEOUT = 32'd100000
) (
    input  logic              CLK,
    input  logic              RSTn,
    uart_tx_arbiter_if.master bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Start "just after" the last requester so requester 0 wins first.
    localparam logic [GW-1:0] LAST_INIT = GW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    last_grant_q, last_grant_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_en_q, tx_en_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;
    logic [31:0]      wdog_q, wdog_d;

    logic [7:0]       req_byte [NREQ];
    logic             win_found;
    logic [GW-1:0]    win_idx;
    logic [GW-1:0]    cand;

    // Split the packed data bus into one byte per requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_byte[gi] = bus.Req_Data[8*gi +: 8];
        end
    endgenerate

    // Round-robin pick: first active request scanning upward from last_grant+1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant_q) + k) % NREQ);
            if (!win_found && bus.Req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and registered-output computation for IDLE -> SEND -> DONE.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        tx_data_d     = tx_data_q;
        tx_en_d       = tx_en_q;
        ack_d         = '0;
        timeout_err_d = 1'b0;
        wdog_d        = wdog_q;

        case (state_q)
            ST_IDLE: begin
                tx_en_d = 1'b0;
                if (win_found) begin
                    grant_d      = win_idx;
                    last_grant_d = win_idx;
                    tx_data_d    = req_byte[win_idx];
                    tx_en_d      = 1'b1;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_en_d = 1'b1;
                wdog_d  = wdog_q + 32'd1;
                // A completion arriving on the last allowed cycle still counts.
                if (bus.TX_Done_Sig) begin
                    tx_en_d        = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = ST_DONE;
                end else if (wdog_q == TIMEOUT - 32'd1) begin
                    tx_en_d       = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                // One cycle with enable low so the UART can rearm.
                tx_en_d = 1'b0;
                wdog_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                tx_en_d = 1'b0;
                wdog_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops the UART enable immediately.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_grant_q  <= LAST_INIT;
            tx_data_q     <= 8'h00;
            tx_en_q       <= 1'b0;
            ack_q         <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            tx_data_q     <= tx_data_d;
            tx_en_q       <= tx_en_d;
            ack_q         <= ack_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            wdog_q        <= wdog_d;
        end
    end

    assign bus.Ack         = ack_q;
    assign bus.Busy        = busy_q;
    assign bus.Timeout_Err = timeout_err_q;
    assign bus.TX_En_Sig   = tx_en_q;
    assign bus.TX_Data     = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected bytes/grants are queued when requests
// are driven and compared as each byte is transmitted.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 20;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus_if ();

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (32'(TMO))
    ) dut (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (bus_if.master)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         idx;
        logic [7:0] data;
        bit         tmo;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input int idx, input logic [7:0] d, input bit tmo);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        e.tmo  = tmo;
        sb.push_back(e);
    endfunction

    // Waits for a grant, serves it (done after done_delay SEND cycles, none if 0),
    // and returns at the negedge inside the DONE cycle.
    task automatic serve(input string tag, input int exp_lat, input int done_delay, input bit mangle);
        exp_t e;
        int n;
        int c;
        logic [NREQ-1:0] exp_ack;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        n = 0;
        while (!bus_if.TX_En_Sig && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_en"}, 32'(bus_if.TX_En_Sig), 32'd1);
        if (exp_lat >= 0) check({tag, "_lat"}, n, exp_lat);
        check({tag, "_busy"}, 32'(bus_if.Busy), 32'd1);
        c = 0;
        while (bus_if.TX_En_Sig && c < 200) begin
            check({tag, "_data"}, 32'(bus_if.TX_Data), 32'(e.data));
            c++;
            if (done_delay > 0 && c == done_delay) bus_if.TX_Done_Sig = 1'b1;
            if (mangle && c == 3) begin
                bus_if.Req[e.idx] = 1'b0;
                bus_if.Req_Data   = '1;
            end
            @(negedge clk);
            bus_if.TX_Done_Sig = 1'b0;
        end
        check({tag, "_len"}, c, e.tmo ? TMO : done_delay);
        exp_ack = e.tmo ? '0 : NREQ'(1 << e.idx);
        check({tag, "_ack"}, 32'(bus_if.Ack), 32'(exp_ack));
        check({tag, "_terr"}, 32'(bus_if.Timeout_Err), 32'(e.tmo));
        check({tag, "_done_busy"}, 32'(bus_if.Busy), 32'd1);
        check({tag, "_done_en"}, 32'(bus_if.TX_En_Sig), 32'd0);
        $display("txn %s: req=%0d data=%02h send_cycles=%0d ack=%b terr=%0d",
                 tag, e.idx, bus_if.TX_Data, c, bus_if.Ack, bus_if.Timeout_Err);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(bus_if.Busy), 32'd0);
        check({tag, "_en"}, 32'(bus_if.TX_En_Sig), 32'd0);
        check({tag, "_ack"}, 32'(bus_if.Ack), 32'd0);
        check({tag, "_terr"}, 32'(bus_if.Timeout_Err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus_if.Req         = '0;
        bus_if.Req_Data    = '0;
        bus_if.TX_Done_Sig = 1'b0;

        // ---- reset state ----
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_data", 32'(bus_if.TX_Data), 32'h00);
        rstn = 1'b1;
        @(negedge clk);

        // ---- 1: single requester, done after 10 cycles ----
        bus_if.Req_Data = {8'h0D, 8'h0C, 8'h0B, 8'h0A};
        bus_if.Req      = 4'b0001;
        push_exp(0, 8'h0A, 1'b0);
        serve("t1", 1, 10, 1'b0);
        bus_if.Req = '0;
        @(negedge clk);
        check_idle("t1_idle");
        // stray done while idle must not ack
        bus_if.TX_Done_Sig = 1'b1;
        @(negedge clk);
        bus_if.TX_Done_Sig = 1'b0;
        @(negedge clk);
        check_idle("t1_stray_done");

        // ---- 2: all four requesting from reset, each drops on its Ack ----
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        bus_if.Req = 4'b1111;
        for (int i = 0; i < 4; i++) push_exp(i, 8'(8'h0A + i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            serve($sformatf("t2_%0d", i), (i == 0) ? 1 : 2, 5 + i, 1'b0);
            bus_if.Req[i] = 1'b0;
        end
        @(negedge clk);
        check_idle("t2_idle");

        // ---- 3: requesters 0 and 2 stream 8 bytes each ----
        bus_if.Req_Data[7:0]   = 8'h10;
        bus_if.Req_Data[23:16] = 8'h20;
        bus_if.Req             = 4'b0101;
        for (int n = 0; n < 8; n++) begin
            push_exp(0, 8'(8'h10 + n), 1'b0);
            push_exp(2, 8'(8'h20 + n), 1'b0);
        end
        for (int j = 0; j < 16; j++) begin
            serve($sformatf("t3_%0d", j), (j == 0) ? 1 : 2, 4, 1'b0);
            if ((j % 2) == 0) begin
                if (j / 2 < 7) bus_if.Req_Data[7:0] = 8'(8'h10 + j / 2 + 1);
                else           bus_if.Req[0] = 1'b0;
            end else begin
                if (j / 2 < 7) bus_if.Req_Data[23:16] = 8'(8'h20 + j / 2 + 1);
                else           bus_if.Req[2] = 1'b0;
            end
        end
        @(negedge clk);
        check_idle("t3_idle");

        // ---- 4: watchdog abort, then rotation moves on ----
        bus_if.Req_Data[7:0]   = 8'hC0;
        bus_if.Req_Data[31:24] = 8'hD3;
        bus_if.Req             = 4'b1001;
        push_exp(3, 8'hD3, 1'b1);
        push_exp(0, 8'hC0, 1'b0);
        push_exp(3, 8'hD3, 1'b0);
        serve("t4_tmo", 1, 0, 1'b0);
        serve("t4_r0", 2, 6, 1'b0);
        bus_if.Req[0] = 1'b0;
        serve("t4_r3", 2, 6, 1'b0);
        bus_if.Req[3] = 1'b0;
        @(negedge clk);
        check_idle("t4_idle");

        // ---- 5: done on the last watchdog cycle; Req/data disturbed mid-send ----
        bus_if.Req_Data[15:8] = 8'h55;
        bus_if.Req            = 4'b0010;
        push_exp(1, 8'h55, 1'b0);
        serve("t5", 1, TMO, 1'b1);
        @(negedge clk);
        check_idle("t5_idle");
        @(negedge clk);
        check_idle("t5_no_regrant");

        // ---- 6: asynchronous reset mid-send ----
        bus_if.Req_Data = {8'h0D, 8'h0C, 8'h0B, 8'h0A};
        bus_if.Req      = 4'b0100;
        @(negedge clk);
        check("t6_en_before", 32'(bus_if.TX_En_Sig), 32'd1);
        check("t6_data_before", 32'(bus_if.TX_Data), 32'h0C);
        repeat (3) @(negedge clk);
        bus_if.Req = 4'b1111;
        rstn       = 1'b0;
        #1;
        check_idle("t6_rst");
        check("t6_rst_data", 32'(bus_if.TX_Data), 32'h00);
        @(negedge clk);
        rstn = 1'b1;
        push_exp(0, 8'h0A, 1'b0);
        serve("t6_after", 1, 5, 1'b0);
        bus_if.Req = '0;
        @(negedge clk);
        check_idle("t6_idle");

        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
